// File: rtl/clk_gate_ctrl_pkg.sv
// Shared types and constants for the per-domain clock-gating controller.
package clk_gate_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_COUNT = 2'b01,
    ST_OFF   = 2'b10,
    ST_WAKE  = 2'b11
  } dom_state_e;

  localparam int unsigned WAKE_CNT_W = 4;

endpackage

// File: rtl/clk_gate_dom_fsm.sv
// One clock domain: idle-detect counter, gate/wake FSM and wake acknowledge.
module clk_gate_dom_fsm
  import clk_gate_ctrl_pkg::*;
#(
  parameter int unsigned IDLE_W   = 8,
  parameter int unsigned WAKE_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              busy,
  input  logic              wake_req,
  input  logic              force_on,
  input  logic [IDLE_W-1:0] idle_thresh,
  output logic              en,
  output logic              wake_ack,
  output logic              gated
);

  localparam logic [WAKE_CNT_W-1:0] WAKE_LAST = WAKE_CNT_W'(WAKE_CYC - 1);

  dom_state_e            state, state_next;
  logic [IDLE_W-1:0]     cnt, cnt_next;
  logic [WAKE_CNT_W-1:0] wcnt, wcnt_next;
  logic                  en_next, gated_next, ack_next;
  logic                  activity;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_RUN;
      cnt      <= '0;
      wcnt     <= '0;
      en       <= 1'b1;
      gated    <= 1'b0;
      wake_ack <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      wcnt     <= wcnt_next;
      en       <= en_next;
      gated    <= gated_next;
      wake_ack <= ack_next;
    end
  end

  // Outputs follow the registered state one cycle later, so en has no input path.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    wcnt_next  = wcnt;
    activity   = busy | force_on | wake_req;
    en_next    = (state != ST_OFF);
    gated_next = (state == ST_OFF);
    ack_next   = (state == ST_RUN) && wake_req && !wake_ack;

    case (state)
      ST_RUN: begin
        if (!activity && (idle_thresh != '0)) begin
          state_next = ST_COUNT;
          cnt_next   = IDLE_W'(1);
        end
      end
      ST_COUNT: begin
        // Activity takes priority over expiry; >= lets a lowered threshold expire at once.
        if (activity || (idle_thresh == '0)) begin
          state_next = ST_RUN;
          cnt_next   = '0;
        end else if (cnt >= idle_thresh) begin
          state_next = ST_OFF;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + IDLE_W'(1);
        end
      end
      ST_OFF: begin
        if (wake_req || force_on) begin
          state_next = ST_WAKE;
          wcnt_next  = '0;
        end
      end
      ST_WAKE: begin
        if (wcnt == WAKE_LAST) begin
          state_next = ST_RUN;
          wcnt_next  = '0;
        end else begin
          wcnt_next = wcnt + WAKE_CNT_W'(1);
        end
      end
      default: state_next = ST_RUN;
    endcase
  end

endmodule

// File: rtl/clk_gate_ctrl.sv
// Bank of independent clock-gate enable controllers sharing one idle threshold.
module clk_gate_ctrl
  import clk_gate_ctrl_pkg::*;
#(
  parameter int unsigned NUM_DOM  = 4,
  parameter int unsigned IDLE_W   = 8,
  parameter int unsigned WAKE_CYC = 2
) (
  input  logic               CK,
  input  logic               RN,
  input  logic [NUM_DOM-1:0] busy,
  input  logic [NUM_DOM-1:0] wake_req,
  input  logic [NUM_DOM-1:0] force_on,
  input  logic [IDLE_W-1:0]  idle_thresh,
  output logic [NUM_DOM-1:0] en,
  output logic [NUM_DOM-1:0] wake_ack,
  output logic [NUM_DOM-1:0] gated
);

  for (genvar i = 0; i < NUM_DOM; i++) begin : g_dom
    clk_gate_dom_fsm #(
      .IDLE_W  (IDLE_W),
      .WAKE_CYC(WAKE_CYC)
    ) u_dom (
      .clk        (CK),
      .rst_n      (RN),
      .busy       (busy[i]),
      .wake_req   (wake_req[i]),
      .force_on   (force_on[i]),
      .idle_thresh(idle_thresh),
      .en         (en[i]),
      .wake_ack   (wake_ack[i]),
      .gated      (gated[i])
    );
  end

endmodule
